sad_disparity_scheduler: RTL and testbench

//   Sequences the 3x3 SAD datapath across the disparity search range for one left-image

---
 rtl/sad_disparity_scheduler_pkg.sv | 18 +
 rtl/sad_disparity_scheduler_min_tracker.sv | 32 +++
 rtl/sad_disparity_scheduler.sv | 119 +++++++++++
 tb/tb_sad_disparity_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_disparity_scheduler_pkg.sv
// Shared types and defaults for the stereo SAD disparity search blocks.
package stereo_pkg;

  localparam int MAX_DISP_DEF = 64;
  localparam int DISP_W_DEF   = 6;
  localparam int COL_W_DEF    = 10;
  localparam int SAD_W_DEF    = 12;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sad_disparity_scheduler_min_tracker.sv
// Running minimum / argmin register for SAD results; strict-less update keeps
// the smallest disparity on ties.
module sad_min_tracker
  import stereo_pkg::*;
#(
  parameter int DISP_W = DISP_W_DEF,
  parameter int SAD_W  = SAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              upd,
  input  logic [SAD_W-1:0]  sad,
  input  logic [DISP_W-1:0] idx,
  output logic [SAD_W-1:0]  min_sad,
  output logic [DISP_W-1:0] best
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad <= '0;
      best    <= '0;
    end else if (clear) begin
      min_sad <= '1;
      best    <= '0;
    end else if (upd && (sad < min_sad)) begin
      min_sad <= sad;
      best    <= idx;
    end
  end

endmodule

// File: rtl/sad_disparity_scheduler.sv
// Walks one window job across the disparity range, issuing one candidate per
// cycle, and reports the disparity with the smallest returned SAD.
module sad_disparity_scheduler
  import stereo_pkg::*;
#(
  parameter int MAX_DISP = MAX_DISP_DEF,
  parameter int DISP_W   = DISP_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int SAD_W    = SAD_W_DEF,
  parameter int SAD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [COL_W-1:0]  job_col,
  output logic              sad_req_valid,
  output logic [DISP_W-1:0] sad_req_disp,
  input  logic              sad_rsp_valid,
  input  logic [SAD_W-1:0]  sad_rsp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DISP_W-1:0] res_disp,
  output logic [SAD_W-1:0]  res_sad
);

  // The scheduler only counts responses, so any fixed latency >= 1 works.
  if ((SAD_LAT < 1) || (MAX_DISP < 2) || ((1 << DISP_W) < MAX_DISP)) begin : g_param_check
    $error("sad_disparity_scheduler: illegal parameter combination");
  end

  localparam logic [COL_W-1:0]  COL_CAP  = COL_W'(MAX_DISP - 1);
  localparam logic [DISP_W-1:0] DISP_CAP = DISP_W'(MAX_DISP - 1);

  state_t            state;
  logic [DISP_W-1:0] last;
  logic [DISP_W-1:0] rsp_cnt;
  logic [DISP_W-1:0] job_last;
  logic              accept;
  logic              rsp_live;

  // Never search past column 0 of the right image.
  assign job_last = (job_col > COL_CAP) ? DISP_CAP : DISP_W'(job_col);
  assign accept   = (state == IDLE) && job_valid;
  assign rsp_live = sad_rsp_valid && ((state == ISSUE) || (state == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      job_ready     <= 1'b1;
      sad_req_valid <= 1'b0;
      sad_req_disp  <= '0;
      rsp_cnt       <= '0;
      last          <= '0;
      res_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            last          <= job_last;
            sad_req_disp  <= '0;
            rsp_cnt       <= '0;
            sad_req_valid <= 1'b1;
            job_ready     <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (sad_req_disp == last) begin
            sad_req_valid <= 1'b0;
            state         <= DRAIN;
          end else begin
            sad_req_disp <= sad_req_disp + 1'b1;
          end
          // The final response always lands in DRAIN, so ISSUE only advances.
          if (sad_rsp_valid && (rsp_cnt != last)) begin
            rsp_cnt <= rsp_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (sad_rsp_valid) begin
            if (rsp_cnt == last) begin
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rsp_cnt <= rsp_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          job_ready <= 1'b1;
        end
      endcase
    end
  end

  sad_min_tracker #(
    .DISP_W (DISP_W),
    .SAD_W  (SAD_W)
  ) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .upd     (rsp_live),
    .sad     (sad_rsp),
    .idx     (rsp_cnt),
    .min_sad (res_sad),
    .best    (res_disp)
  );

endmodule

// File: tb/tb_sad_disparity_scheduler.sv
// Directed bench for sad_disparity_scheduler with a behavioural SAD responder
// of run-time selectable latency and a result scoreboard.
module tb_sad_disparity_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [9:0]  job_col;
  logic        sad_req_valid;
  logic [5:0]  sad_req_disp;
  logic        sad_rsp_valid;
  logic [11:0] sad_rsp;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_disp;
  logic [11:0] res_sad;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int lat    = 1;

  typedef struct {
    int disp;
    int sad;
    int last;
    int lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sad_disparity_scheduler #(
    .MAX_DISP (64),
    .DISP_W   (6),
    .COL_W    (10),
    .SAD_W    (12),
    .SAD_LAT  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_col       (job_col),
    .sad_req_valid (sad_req_valid),
    .sad_req_disp  (sad_req_disp),
    .sad_rsp_valid (sad_rsp_valid),
    .sad_rsp       (sad_rsp),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_disp      (res_disp),
    .res_sad       (res_sad)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      $error("%s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sad_fn(input int m, input int d);
    int a;
    case (m)
      0: begin
        a = (d > 17) ? (d - 17) : (17 - d);
        return a * 10 + 5;
      end
      1: return ((d == 5) || (d == 9)) ? 40 : 100 + d;
      2: return 2295;
      default: return ((d * 53 + 7) % 97) + 3;
    endcase
  endfunction

  // SAD datapath stand-in: responses delayed by 'lat' cycles, request order checked.
  logic pv[0:7];
  int   ps[0:7];
  logic prev_req = 1'b0;
  int   exp_next = 0;
  int   req_cnt  = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      ps[i] = 0;
    end
    sad_rsp_valid = 1'b0;
    sad_rsp       = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
      prev_req      = 1'b0;
      sad_rsp_valid = 1'b0;
      sad_rsp       = '0;
    end else begin
      if (sad_req_valid) begin
        if (!prev_req) begin
          exp_next = 0;
          req_cnt  = 0;
        end
        check("req_disp", 32'(sad_req_disp), exp_next);
        exp_next++;
        req_cnt++;
      end
      prev_req = sad_req_valid;
      for (int i = 7; i > 0; i--) begin
        pv[i] = pv[i-1];
        ps[i] = ps[i-1];
      end
      pv[0] = sad_req_valid;
      ps[0] = sad_fn(mode, int'(sad_req_disp));
      sad_rsp_valid = pv[lat];
      sad_rsp       = 12'(ps[lat]);
    end
  end

  task automatic start_job(input int col, input int m, input int l, input bit push);
    int   n;
    int   last;
    exp_t e;
    n = 0;
    while (!job_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("job_ready_wait", 32'(job_ready), 1);
    mode = m;
    lat  = l;
    if (push) begin
      last   = (col < 63) ? col : 63;
      e.disp = 0;
      e.sad  = 4095;
      e.last = last;
      e.lat  = l;
      for (int d = 0; d <= last; d++) begin
        if (sad_fn(m, d) < e.sad) begin
          e.sad  = sad_fn(m, d);
          e.disp = d;
        end
      end
      sb.push_back(e);
    end
    job_valid = 1'b1;
    job_col   = 10'(col);
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input int hold, input bit pre);
    int   n;
    exp_t e;
    n = 1;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty observed=0 expected=1");
      $fatal(1, "scoreboard empty");
    end
    e = sb.pop_front();
    check("res_latency", n, 2 + e.last + e.lat);
    check("req_count", req_cnt, e.last + 1);
    check("res_disp", 32'(res_disp), e.disp);
    check("res_sad", 32'(res_sad), e.sad);
    check("job_ready_done", 32'(job_ready), 0);
    for (int h = 0; h < hold; h++) begin
      job_valid = pre;
      job_col   = '0;
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 1);
      check("hold_disp", 32'(res_disp), e.disp);
      check("hold_sad", 32'(res_sad), e.sad);
      check("hold_no_req", 32'(sad_req_valid), 0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("retire_valid", 32'(res_valid), 0);
    check("retire_ready", 32'(job_ready), 1);
    check("retire_no_req", 32'(sad_req_valid), 0);
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    job_valid = 1'b0;
    job_col   = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", 32'(job_ready), 1);
    check("rst_req_valid", 32'(sad_req_valid), 0);
    check("rst_req_disp", 32'(sad_req_disp), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_disp", 32'(res_disp), 0);
    check("rst_res_sad", 32'(res_sad), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full range, V-shaped cost with minimum at 17.
    start_job(100, 0, 1, 1'b1);
    finish_job(0, 1'b0);

    // Column limits the search to d=0..3.
    start_job(3, 0, 1, 1'b1);
    finish_job(0, 1'b0);

    // Tie at d=5 and d=9 resolves to the smaller disparity.
    start_job(20, 1, 1, 1'b1);
    finish_job(0, 1'b0);

    // Flat maximum cost, result held while the consumer stalls.
    start_job(63, 2, 1, 1'b1);
    finish_job(10, 1'b0);

    // Asynchronous reset in the middle of issuing.
    start_job(100, 0, 1, 1'b0);
    n = 0;
    while (!(sad_req_valid && sad_req_disp == 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_d20", 32'(sad_req_disp), 20);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(sad_req_valid), 0);
    check("midrst_job_ready", 32'(job_ready), 1);
    check("midrst_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(sad_req_valid), 0);

    // Latency 3, back-to-back jobs; a pending job must wait for the handshake.
    start_job(0, 3, 3, 1'b1);
    finish_job(3, 1'b1);
    start_job(63, 3, 3, 1'b1);
    finish_job(0, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
